ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 16-bit ISA.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 ex_vld  input  1  EX-stage instruction valid (not a bubble).
REQ-005 ex_opcode  input  4  EX-stage opcode.
REQ-006 ex_alu_out  input  16  ALU result (sum/address, shift, XOR, RED, PADDSB, LHB/LLB, PCS).
REQ-007 ex_alu_flag  input  3  ALU combinational flags, bit 2 = N, bit 1 = V, bit 0 = Z.
REQ-008 ex_store_data  input  16  forwarded rt value for SW.
REQ-009 ex_rd  input  4  destination register number.
REQ-010 ex_reg_wr  input  1  instruction writes register file.
REQ-011 stall  input  1  hold all pipeline registers this cycle.
REQ-012 flush  input  1  replace the captured instruction with a bubble.
REQ-013 mem_vld, mem_reg_wr, mem_rd_en, mem_wr_en, mem_halt  output  1 each  registered MEM-stage controls.
REQ-014 mem_opcode  output  4;  mem_rd  output  4;  mem_alu_out, mem_store_data  output  16 each  registered EX results.
REQ-015 flag_q  output  3  architectural flag register {N,V,Z}.
REQ-016 flag_fwd  output  3  next-cycle flag value, for same-cycle branch resolution in decode.

Function
REQ-017 Opcode map: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1000 LW, 1001 SW, 1010 LHB, 1011 LLB, 1100 B, 1101 BR, 1110 PCS, 1111 HLT.
REQ-018 Capture condition "adv" = !stall && !flush; on adv all mem_* registers load from ex_* inputs in one cycle (latency 1).
REQ-019 On adv, mem_vld <= ex_vld; when ex_vld = 0, mem_reg_wr, mem_rd_en, mem_wr_en and mem_halt SHALL load 0 regardless of other inputs.
REQ-020 mem_rd_en <= ex_vld && opcode 1000; mem_wr_en <= ex_vld && opcode 1001; mem_halt <= ex_vld && opcode 1111.
REQ-021 mem_reg_wr <= ex_vld && ex_reg_wr && opcode not in {1001, 1100, 1101, 1111}.
REQ-022 On stall with flush = 0, every mem_* register and flag_q SHALL hold its value.
REQ-023 Flush has priority over stall: on flush, mem_vld, mem_reg_wr, mem_rd_en, mem_wr_en, mem_halt <= 0; data registers may hold; flag_q holds.
REQ-024 Flag write enables (only when ex_vld && adv): ADD/SUB write N, V, Z; XOR/SLL/SRA/ROR write Z only; all other opcodes write no flag bits.
REQ-025 Flag bits without a write enable SHALL retain their prior values; enabled bits take the ex_alu_flag bit.
REQ-026 flag_fwd SHALL be the combinational value flag_q will hold after the current edge (write-enable merge of ex_alu_flag into flag_q).
REQ-027 Once mem_halt = 1 with mem_vld = 1, the block SHALL ignore further adv (sticky halt) until rst; flag_q freezes.
REQ-028 A bubble (ex_vld = 0) SHALL never alter flag_q.

Reset
REQ-029 When rst = 1 at a rising edge, all outputs SHALL clear to 0 (mem_* registers, flag_q = 3'b000, sticky halt cleared), overriding stall and flush.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight instruction; first capture occurs on the first edge with rst = 0 and adv = 1.

Verification
REQ-031 rst for 2 cycles, then ADD vld, alu_out 16'h8000, flag 3'b110 -> next cycle mem_alu_out 16'h8000, mem_reg_wr 1, flag_q 3'b110.
REQ-032 flag_q 3'b110, then XOR vld, flag 3'b001 -> flag_q 3'b111; then LLB vld, flag 3'b000 -> flag_q stays 3'b111.
REQ-033 SW vld, alu_out 16'h0010, store_data 16'hBEEF, stall 1 for 2 cycles then 0 -> outputs hold previous values during stall, then mem_wr_en 1, mem_reg_wr 0, mem_store_data 16'hBEEF.
REQ-034 SUB vld with flag 3'b001 and flush 1 and stall 1 same cycle -> mem_vld 0, mem_reg_wr 0, flag_q unchanged, flag_fwd equals flag_q.
REQ-035 HLT vld -> mem_halt 1; subsequent ADD vld with flag 3'b001 -> mem_* and flag_q unchanged; rst -> all outputs 0.
REQ-036 ADD with ex_vld 0, flag 3'b111 -> mem_vld 0, all write enables 0, flag_q unchanged.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with {N,V,Z} flag register and sticky halt
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_vld,
   input  logic [3:0]  ex_opcode,
   input  logic [15:0] ex_alu_out,
   input  logic [2:0]  ex_alu_flag,
   input  logic [15:0] ex_store_data,
   input  logic [3:0]  ex_rd,
   input  logic        ex_reg_wr,
   input  logic        stall,
   input  logic        flush,
   output logic        mem_vld,
   output logic        mem_reg_wr,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic        mem_halt,
   output logic [3:0]  mem_opcode,
   output logic [3:0]  mem_rd,
   output logic [15:0] mem_alu_out,
   output logic [15:0] mem_store_data,
   output logic [2:0]  flag_q,
   output logic [2:0]  flag_fwd
);

   localparam logic [3:0] c_OP_ADD = 4'b0000;
   localparam logic [3:0] c_OP_SUB = 4'b0001;
   localparam logic [3:0] c_OP_XOR = 4'b0010;
   localparam logic [3:0] c_OP_SLL = 4'b0100;
   localparam logic [3:0] c_OP_SRA = 4'b0101;
   localparam logic [3:0] c_OP_ROR = 4'b0110;
   localparam logic [3:0] c_OP_LW  = 4'b1000;
   localparam logic [3:0] c_OP_SW  = 4'b1001;
   localparam logic [3:0] c_OP_B   = 4'b1100;
   localparam logic [3:0] c_OP_BR  = 4'b1101;
   localparam logic [3:0] c_OP_HLT = 4'b1111;

   logic        r_mem_vld;
   logic        r_mem_reg_wr;
   logic        r_mem_rd_en;
   logic        r_mem_wr_en;
   logic        r_mem_halt;
   logic [3:0]  r_mem_opcode;
   logic [3:0]  r_mem_rd;
   logic [15:0] r_mem_alu_out;
   logic [15:0] r_mem_store_data;
   logic [2:0]  r_flag_q;

   logic        w_halted;
   logic        w_cap;
   logic        w_reg_wr_ok;
   logic [2:0]  w_flag_we;
   logic [2:0]  w_flag_nxt;

   // A halt that has reached MEM freezes the whole stage until reset.
   assign w_halted    = r_mem_halt & r_mem_vld;
   assign w_cap       = !stall && !flush && !w_halted;
   assign w_reg_wr_ok = ex_vld && ex_reg_wr &&
                        (ex_opcode != c_OP_SW) && (ex_opcode != c_OP_B) &&
                        (ex_opcode != c_OP_BR) && (ex_opcode != c_OP_HLT);

   always_comb begin
      w_flag_we  = 3'b000;
      w_flag_nxt = r_flag_q;
      case (ex_opcode)
         c_OP_ADD, c_OP_SUB:                     w_flag_we = 3'b111;
         c_OP_XOR, c_OP_SLL, c_OP_SRA, c_OP_ROR: w_flag_we = 3'b001;
         default:                                w_flag_we = 3'b000;
      endcase
      if (!(ex_vld && w_cap))
         w_flag_we = 3'b000;
      w_flag_nxt = (ex_alu_flag & w_flag_we) | (r_flag_q & ~w_flag_we);
      if (rst)
         w_flag_nxt = 3'b000;
   end

   always_ff @(posedge clk) begin
      r_flag_q <= w_flag_nxt;
      if (rst) begin
         r_mem_vld        <= 1'b0;
         r_mem_reg_wr     <= 1'b0;
         r_mem_rd_en      <= 1'b0;
         r_mem_wr_en      <= 1'b0;
         r_mem_halt       <= 1'b0;
         r_mem_opcode     <= 4'd0;
         r_mem_rd         <= 4'd0;
         r_mem_alu_out    <= 16'd0;
         r_mem_store_data <= 16'd0;
      end else if (w_halted) begin
         r_mem_vld <= r_mem_vld;
      end else if (flush) begin
         // Data fields are left as-is; only the controls are squashed.
         r_mem_vld    <= 1'b0;
         r_mem_reg_wr <= 1'b0;
         r_mem_rd_en  <= 1'b0;
         r_mem_wr_en  <= 1'b0;
         r_mem_halt   <= 1'b0;
      end else if (!stall) begin
         r_mem_vld        <= ex_vld;
         r_mem_reg_wr     <= w_reg_wr_ok;
         r_mem_rd_en      <= ex_vld && (ex_opcode == c_OP_LW);
         r_mem_wr_en      <= ex_vld && (ex_opcode == c_OP_SW);
         r_mem_halt       <= ex_vld && (ex_opcode == c_OP_HLT);
         r_mem_opcode     <= ex_opcode;
         r_mem_rd         <= ex_rd;
         r_mem_alu_out    <= ex_alu_out;
         r_mem_store_data <= ex_store_data;
      end
   end

   assign mem_vld        = r_mem_vld;
   assign mem_reg_wr     = r_mem_reg_wr;
   assign mem_rd_en      = r_mem_rd_en;
   assign mem_wr_en      = r_mem_wr_en;
   assign mem_halt       = r_mem_halt;
   assign mem_opcode     = r_mem_opcode;
   assign mem_rd         = r_mem_rd;
   assign mem_alu_out    = r_mem_alu_out;
   assign mem_store_data = r_mem_store_data;
   assign flag_q         = r_flag_q;
   assign flag_fwd       = w_flag_nxt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : directed + randomized self-checking bench with behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_vld;
   logic [3:0]  ex_opcode;
   logic [15:0] ex_alu_out;
   logic [2:0]  ex_alu_flag;
   logic [15:0] ex_store_data;
   logic [3:0]  ex_rd;
   logic        ex_reg_wr;
   logic        stall;
   logic        flush;
   logic        mem_vld, mem_reg_wr, mem_rd_en, mem_wr_en, mem_halt;
   logic [3:0]  mem_opcode, mem_rd;
   logic [15:0] mem_alu_out, mem_store_data;
   logic [2:0]  flag_q, flag_fwd;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk(clk), .rst(rst), .ex_vld(ex_vld), .ex_opcode(ex_opcode),
      .ex_alu_out(ex_alu_out), .ex_alu_flag(ex_alu_flag),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
      .stall(stall), .flush(flush),
      .mem_vld(mem_vld), .mem_reg_wr(mem_reg_wr), .mem_rd_en(mem_rd_en),
      .mem_wr_en(mem_wr_en), .mem_halt(mem_halt), .mem_opcode(mem_opcode),
      .mem_rd(mem_rd), .mem_alu_out(mem_alu_out),
      .mem_store_data(mem_store_data), .flag_q(flag_q), .flag_fwd(flag_fwd)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic        started = 1'b0;
   logic        m_vld, m_reg_wr, m_rd_en, m_wr_en, m_halt;
   logic [3:0]  m_op, m_rd;
   logic [15:0] m_alu, m_sd;
   logic [2:0]  m_flag;

   function automatic logic [2:0] flag_mask(input logic [3:0] op);
      if (op == 4'd0 || op == 4'd1) return 3'b111;
      if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b001;
      return 3'b000;
   endfunction

   function automatic logic [2:0] model_next_flag();
      logic [2:0] m;
      if (rst) return 3'b000;
      if (m_halt && m_vld) return m_flag;
      if (!ex_vld || stall || flush) return m_flag;
      m = flag_mask(ex_opcode);
      return (ex_alu_flag & m) | (m_flag & ~m);
   endfunction

   always @(posedge clk) begin
      logic [2:0] nf;
      nf = model_next_flag();
      if (rst) begin
         started = 1'b1;
         {m_vld, m_reg_wr, m_rd_en, m_wr_en, m_halt} = 5'b0;
         m_op = 4'd0; m_rd = 4'd0; m_alu = 16'd0; m_sd = 16'd0;
      end else if (m_halt && m_vld) begin
         m_vld = m_vld;
      end else if (flush) begin
         {m_vld, m_reg_wr, m_rd_en, m_wr_en, m_halt} = 5'b0;
      end else if (!stall) begin
         m_vld    = ex_vld;
         m_reg_wr = ex_vld && ex_reg_wr &&
                    !(ex_opcode inside {4'd9, 4'd12, 4'd13, 4'd15});
         m_rd_en  = ex_vld && ex_opcode == 4'd8;
         m_wr_en  = ex_vld && ex_opcode == 4'd9;
         m_halt   = ex_vld && ex_opcode == 4'd15;
         m_op = ex_opcode; m_rd = ex_rd; m_alu = ex_alu_out; m_sd = ex_store_data;
      end
      m_flag = nf;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("mem_vld",    {15'd0, mem_vld},    {15'd0, m_vld});
         chk("mem_reg_wr", {15'd0, mem_reg_wr}, {15'd0, m_reg_wr});
         chk("mem_rd_en",  {15'd0, mem_rd_en},  {15'd0, m_rd_en});
         chk("mem_wr_en",  {15'd0, mem_wr_en},  {15'd0, m_wr_en});
         chk("mem_halt",   {15'd0, mem_halt},   {15'd0, m_halt});
         chk("flag_q",     {13'd0, flag_q},     {13'd0, m_flag});
         chk("flag_fwd",   {13'd0, flag_fwd},   {13'd0, model_next_flag()});
         if (m_vld) begin
            chk("mem_opcode",     {12'd0, mem_opcode}, {12'd0, m_op});
            chk("mem_rd",         {12'd0, mem_rd},     {12'd0, m_rd});
            chk("mem_alu_out",    mem_alu_out,         m_alu);
            chk("mem_store_data", mem_store_data,      m_sd);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] alu,
                        input logic [2:0] fl, input logic [15:0] sd);
      ex_vld = v; ex_opcode = op; ex_alu_out = alu; ex_alu_flag = fl;
      ex_store_data = sd; ex_rd = 4'd3; ex_reg_wr = 1'b1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 4'd0, 16'd0, 3'd0, 16'd0);
      step(); step();
      chk("rst_mem_vld", {15'd0, mem_vld}, 16'd0);
      chk("rst_flag_q",  {13'd0, flag_q},  16'd0);

      rst = 1'b0;
      drive(1'b1, 4'b0000, 16'h8000, 3'b110, 16'h0);
      step();
      chk("add_alu_out", mem_alu_out, 16'h8000);
      chk("add_reg_wr",  {15'd0, mem_reg_wr}, 16'd1);
      chk("add_flag_q",  {13'd0, flag_q}, 16'h6);
      chk("model_add_flag", {13'd0, m_flag}, 16'h6);

      drive(1'b1, 4'b0010, 16'h1, 3'b001, 16'h0);
      step();
      chk("xor_flag_q", {13'd0, flag_q}, 16'h7);
      drive(1'b1, 4'b1011, 16'h2, 3'b000, 16'h0);
      step();
      chk("llb_flag_q", {13'd0, flag_q}, 16'h7);

      drive(1'b1, 4'b1001, 16'h0010, 3'b000, 16'hBEEF);
      stall = 1'b1;
      step();
      chk("stall1_opcode", {12'd0, mem_opcode}, 16'hB);
      chk("stall1_wr_en",  {15'd0, mem_wr_en}, 16'd0);
      step();
      chk("stall2_alu_out", mem_alu_out, 16'h2);
      stall = 1'b0;
      step();
      chk("sw_wr_en",  {15'd0, mem_wr_en}, 16'd1);
      chk("sw_reg_wr", {15'd0, mem_reg_wr}, 16'd0);
      chk("sw_store",  mem_store_data, 16'hBEEF);
      chk("sw_alu",    mem_alu_out, 16'h0010);

      drive(1'b1, 4'b0001, 16'h5, 3'b001, 16'h0);
      stall = 1'b1; flush = 1'b1;
      #1;
      chk("flush_flag_fwd", {13'd0, flag_fwd}, 16'h7);
      step();
      chk("flush_vld",    {15'd0, mem_vld}, 16'd0);
      chk("flush_reg_wr", {15'd0, mem_reg_wr}, 16'd0);
      chk("flush_flag_q", {13'd0, flag_q}, 16'h7);
      stall = 1'b0; flush = 1'b0;

      drive(1'b1, 4'b0000, 16'h9, 3'b000, 16'h0);
      step();
      chk("add0_flag_q", {13'd0, flag_q}, 16'h0);
      drive(1'b0, 4'b0000, 16'h9, 3'b111, 16'h0);
      step();
      chk("bubble_vld",    {15'd0, mem_vld}, 16'd0);
      chk("bubble_reg_wr", {15'd0, mem_reg_wr}, 16'd0);
      chk("bubble_flag_q", {13'd0, flag_q}, 16'h0);

      drive(1'b1, 4'b1111, 16'h0, 3'b000, 16'h0);
      step();
      chk("hlt_halt", {15'd0, mem_halt}, 16'd1);
      drive(1'b1, 4'b0000, 16'h1234, 3'b001, 16'h0);
      step();
      chk("halted_alu",    mem_alu_out, 16'h0);
      chk("halted_opcode", {12'd0, mem_opcode}, 16'hF);
      chk("halted_flag_q", {13'd0, flag_q}, 16'h0);
      chk("halted_halt",   {15'd0, mem_halt}, 16'd1);
      rst = 1'b1;
      step();
      chk("rst2_halt",   {15'd0, mem_halt}, 16'd0);
      chk("rst2_vld",    {15'd0, mem_vld}, 16'd0);
      chk("rst2_alu",    mem_alu_out, 16'h0);
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         rst           = ($urandom_range(0, 31) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 7) == 0);
         ex_vld        = ($urandom_range(0, 4) != 0);
         ex_opcode     = 4'($urandom_range(0, 15));
         ex_alu_out    = 16'($urandom);
         ex_alu_flag   = 3'($urandom_range(0, 7));
         ex_store_data = 16'($urandom);
         ex_rd         = 4'($urandom_range(0, 15));
         ex_reg_wr     = 1'($urandom_range(0, 1));
         step();
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
